sifive_rr_grant_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream beat channel between N requesters.
//  - A grant locks for a whole burst and is released only after the beat flagged last is accepted.
//  - Grants are registered, and at most one requester is granted at any time (one-hot).
//  - Sits in front of a shared resource port, ahead of the pairwise-exclusion grant monitors.

---
 rtl/sifive_rr_arb_pkg.sv | 47 ++++
 rtl/sifive_rr_priority_pick.sv | 32 +++
 rtl/sifive_rr_grant_arbiter.sv | 155 +++++++++++++++
 tb/tb_sifive_rr_grant_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sifive_rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / BUSY)
//   rr_pick_t    : result of a rotate-priority search (found flag + index)
//   rr_pick()    : first set request bit at or above ptr, wrapping at n
//   idx_width()  : width of a requester index for n requesters
//   cnt_width()  : width of a counter that must hold 0..m
package sifive_rr_arb_pkg;

    localparam int unsigned MAX_N     = 8;
    localparam int unsigned MAX_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

    // Walks n positions starting at ptr; the first valid bit seen wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]     req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int unsigned          n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = (int'(ptr) + i) % n;
            if ((i < n) && !r.found && req[MAX_IDX_W'(j)]) begin
                r.found = 1'b1;
                r.idx   = MAX_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sifive_rr_priority_pick.sv
// Combinational rotate-priority encoder for the arbiter's IDLE cycle.
//   req   in  N   request vector
//   ptr   in  IW  search start position (round-robin pointer)
//   found out 1   at least one request bit is set
//   idx   out IW  index of the winning requester (0 when none)
module sifive_rr_priority_pick
    import sifive_rr_arb_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [MAX_N-1:0]     req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    rr_pick_t             pick;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        ptr_ext          = '0;
        ptr_ext[IW-1:0]  = ptr;
        pick             = rr_pick(req_ext, ptr_ext, N);
        found            = pick.found;
        idx              = IW'(pick.idx);
    end

endmodule

// File: rtl/sifive_rr_grant_arbiter.sv
// Round-robin arbiter sharing one beat channel between N requesters.
// A grant is locked for a whole burst and released after the beat
// flagged last is accepted; the pointer then moves past the winner.
//   clock, reset         single clock, synchronous active-high reset
//   req_valid/req_last   per-requester beat valid / last flag
//   req_ready            ready back to the granted requester only
//   out_valid/out_last   granted requester's beat, combinational
//   out_ready            downstream accepts the beat
//   out_sel, grant       registered winner index / one-hot grant
//   busy                 1 while a burst owns the channel
//   err_overrun          1-cycle pulse when a burst hits MAX_BEATS without last
// Optional: define SIFIVE_RR_ARB_ASSERT_EN to add a simulation-only checker.
//
// state | meaning
// IDLE  | no owner; arbitrate among req_valid, no beat passes
// BUSY  | grant held; beats of the owner pass straight through
module sifive_rr_grant_arbiter
    import sifive_rr_arb_pkg::*;
#(
    parameter  int unsigned N         = 3,
    parameter  int unsigned MAX_BEATS = 16,
    localparam int unsigned IW        = idx_width(N),
    localparam int unsigned CW        = cnt_width(MAX_BEATS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_last,
    output logic [N-1:0]  req_ready,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [IW-1:0] out_sel,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic          err_overrun
);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          fire;

    sifive_rr_priority_pick #(.N(N)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Beat pass-through is purely combinational from the held selection.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == BUSY) begin
            out_valid = req_valid[sel_q];
            out_last  = req_last[sel_q];
            req_ready = grant_q & {N{out_ready}};
        end
    end

    assign fire = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = BUSY;
                    sel_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            BUSY: begin
                if (fire) begin
                    if (out_last) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        sel_d      = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
                    end else if (beat_cnt_q != CW'(MAX_BEATS)) begin
                        // Counter saturates; only the step onto MAX_BEATS flags.
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        err_d      = (beat_cnt_q == CW'(MAX_BEATS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant       = grant_q;
    assign out_sel     = sel_q;
    assign busy        = (state_q == BUSY);
    assign err_overrun = err_q;

`ifdef SIFIVE_RR_ARB_ASSERT_EN
`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
`ifndef STOP_COND
`define STOP_COND 1'b1
`endif
    always @(posedge clock) begin
        if (!reset) begin
            if (!$onehot0(grant_q)) begin
                if (`PRINTF_COND) $display("rr_arb: grant not one-hot %b", grant_q);
                if (`STOP_COND) $fatal(1);
            end
            if (!$onehot0(req_ready)) begin
                if (`PRINTF_COND) $display("rr_arb: req_ready multi-hot %b", req_ready);
                if (`STOP_COND) $fatal(1);
            end
            if ((state_q == BUSY) && (grant_d != grant_q) && !(fire && out_last)) begin
                if (`PRINTF_COND) $display("rr_arb: grant changed mid-burst");
                if (`STOP_COND) $fatal(1);
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sifive_rr_grant_arbiter.sv
module tb_sifive_rr_grant_arbiter;

    localparam int N   = 3;
    localparam int MAX = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_valid = '1;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b1;
    logic [1:0]   out_sel;
    logic [N-1:0] grant;
    logic         busy;
    logic         err_overrun;

    int total = 0;
    int bad   = 0;

    sifive_rr_grant_arbiter #(.N(N), .MAX_BEATS(MAX)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .grant       (grant),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Behavioural model: owner index (-1 = nobody), pointer, beats so far.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_beats = 0;
    bit           m_err   = 0;
    int           cyc_n   = 0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] gq[$];
    int           gc[$];
    int           err_seen = 0;

    always @(negedge clock) begin
        logic [N-1:0] eg, er;
        logic         ev, el;
        bool_found: begin end
        cyc_n++;
        eg = '0; er = '0; ev = 1'b0; el = 1'b0;
        if (m_owner >= 0) begin
            eg = 3'b001 << m_owner;
            ev = bit_at(req_valid, m_owner);
            el = bit_at(req_last, m_owner);
            er = out_ready ? eg : '0;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("out_sel", 32'(out_sel), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_last", 32'(out_last), 32'(el));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("err_overrun", 32'(err_overrun), 32'(m_err));

        if (grant != '0 && prev_grant == '0) begin
            gq.push_back(grant);
            gc.push_back(cyc_n);
        end
        prev_grant = grant;
        if (err_overrun === 1'b1) err_seen++;

        if (reset) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && bit_at(req_valid, (m_ptr + k) % N))
                        m_owner = (m_ptr + k) % N;
                end
            end else if (ev && out_ready) begin
                if (el) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_beats = 0;
                end else if (m_beats < MAX) begin
                    m_beats++;
                    if (m_beats == MAX) m_err = 1;
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
        @(posedge clock);
        #3;
        reset = rst; req_valid = v; req_last = l; out_ready = r;
    endtask

    task automatic look();
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_seq [6];
        logic [N-1:0] l;
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset held with all requesters valid
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'b111, 3'b000, 1'b1);
            look();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // Fairness: continuous single-beat bursts from everyone
        gq.delete(); gc.delete();
        for (int i = 0; i < 14; i++) cyc(1'b0, 3'b111, 3'b111, 1'b1);
        chk("fair_count_ok", 32'(gq.size() >= 6), 32'd1);
        if (gq.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("fair_order", 32'(gq[i]), 32'(exp_seq[i]));
            for (int i = 1; i < 6; i++) chk("fair_spacing", 32'(gc[i] - gc[i-1]), 32'd2);
        end
        cyc(1'b1, 3'b000, 3'b000, 1'b1);

        // Lock: req0 four beats while req1 waits
        err_seen = 0;
        cyc(1'b0, 3'b011, 3'b000, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            cyc(1'b0, 3'b011, (b == 4) ? 3'b001 : 3'b000, 1'b1);
            look();
            chk("lock_grant", 32'(grant), 32'b001);
            chk("lock_ready", 32'(req_ready), 32'b001);
        end
        cyc(1'b0, 3'b011, 3'b000, 1'b1);
        look();
        chk("lock_dead", 32'(grant), 32'd0);
        cyc(1'b0, 3'b011, 3'b000, 1'b1);
        look();
        chk("lock_next", 32'(grant), 32'b010);
        chk("lock_no_err", 32'(err_seen), 32'd0);
        cyc(1'b1, 3'b000, 3'b000, 1'b1);

        // Backpressure mid-burst
        err_seen = 0;
        cyc(1'b0, 3'b001, 3'b000, 1'b1);
        cyc(1'b0, 3'b001, 3'b000, 1'b1);
        cyc(1'b0, 3'b001, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 3'b001, 3'b000, 1'b0);
            look();
            chk("bp_grant", 32'(grant), 32'b001);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        cyc(1'b0, 3'b001, 3'b000, 1'b1);
        cyc(1'b0, 3'b001, 3'b001, 1'b1);
        cyc(1'b0, 3'b000, 3'b000, 1'b1);
        look();
        chk("bp_release", 32'(grant), 32'd0);
        chk("bp_no_err", 32'(err_seen), 32'd0);
        cyc(1'b1, 3'b000, 3'b000, 1'b1);

        // Overrun: six beats against a limit of four
        err_seen = 0;
        cyc(1'b0, 3'b001, 3'b000, 1'b1);
        for (int b = 1; b <= 6; b++) begin
            cyc(1'b0, 3'b001, (b == 6) ? 3'b001 : 3'b000, 1'b1);
            look();
            chk("ovr_grant", 32'(grant), 32'b001);
            if (b == 5) chk("ovr_pulse", 32'(err_overrun), 32'd1);
        end
        cyc(1'b0, 3'b000, 3'b000, 1'b1);
        look();
        chk("ovr_release", 32'(grant), 32'd0);
        chk("ovr_pulses", 32'(err_seen), 32'd1);
        cyc(1'b1, 3'b000, 3'b000, 1'b1);

        // Reset during beat 2 of req2's burst
        cyc(1'b0, 3'b100, 3'b000, 1'b1);
        cyc(1'b0, 3'b100, 3'b000, 1'b1);
        look();
        chk("rmid_grant", 32'(grant), 32'b100);
        cyc(1'b1, 3'b101, 3'b000, 1'b1);
        cyc(1'b0, 3'b101, 3'b000, 1'b1);
        look();
        chk("rmid_drop", 32'(grant), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        cyc(1'b0, 3'b101, 3'b000, 1'b1);
        look();
        chk("rmid_req0", 32'(grant), 32'b001);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 2) == 0);
            cyc(($urandom_range(0, 299) == 0), N'($urandom_range(0, 7)), l,
                ($urandom_range(0, 3) != 0));
        end

        cyc(1'b1, 3'b000, 3'b000, 1'b1);
        look();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
